// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator/checker pair: FSM states and seeds.
package fib_pkg;

  typedef enum logic {
    FIB_CHECK,
    FIB_HUNT
  } fib_state_t;

  localparam int unsigned FIB_SEED0 = 0;
  localparam int unsigned FIB_SEED1 = 1;

endpackage

// File: rtl/fib_ripple_adder.sv
// Combinational ripple-carry adder; the carry out of the top bit is not produced.
module fib_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    // Modulo-2^WIDTH arithmetic: the final carry is simply never generated.
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/fib_stream_checker.sv
// Checks a valid/ready stream against the Fibonacci recurrence, reporting
// mismatches through an acknowledged error port and keeping saturating statistics.
module fib_stream_checker
  import fib_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LOCK_THRESH = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             err_valid,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  input  logic             err_ack,
  output logic             locked,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] RUN_MAX = 8'(LOCK_THRESH);

  fib_state_t       state;
  logic [WIDTH-1:0] prev_a;
  logic [WIDTH-1:0] prev_b;
  logic [WIDTH-1:0] expected;
  logic [7:0]       run;
  logic             accept;

  fib_ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a  (prev_a),
    .b  (prev_b),
    .sum(expected)
  );

  assign in_ready = ~err_valid;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FIB_CHECK;
      prev_a    <= WIDTH'(FIB_SEED0);
      prev_b    <= WIDTH'(FIB_SEED1);
      err_valid <= 1'b0;
      err_exp   <= '0;
      err_got   <= '0;
      locked    <= 1'b0;
      run       <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (err_valid && err_ack) begin
        err_valid <= 1'b0;
      end
      if (accept) begin
        prev_a <= prev_b;
        prev_b <= in_data;
        case (state)
          FIB_CHECK: begin
            if (in_data == expected) begin
              if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
              if (run != RUN_MAX) run <= run + 8'd1;
              // locked follows the post-increment run count.
              if (run >= RUN_MAX - 8'd1) locked <= 1'b1;
            end else begin
              err_valid <= 1'b1;
              err_exp   <= expected;
              err_got   <= in_data;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              run       <= '0;
              locked    <= 1'b0;
              state     <= FIB_HUNT;
            end
          end
          FIB_HUNT: state <= FIB_CHECK;
          default:  state <= FIB_CHECK;
        endcase
      end
    end
  end

endmodule
